// File: rtl/ehl_fifo_warb.sv
// Burst-atomic round-robin write-port arbiter in front of an ehl_fifo_wc FIFO.
// Optional per-requester stall counters: define EHL_FIFO_WARB_STAT_EN.
module ehl_fifo_warb #(
  parameter int N_REQ     = 4,
  parameter int DW        = 32,
  parameter int LEN_W     = 4,
  parameter int CREDIT_W  = 6,
  parameter int FIFO_SIZE = 32
) (
  input  logic                  wclk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ-1:0]      vld,
  input  logic [N_REQ*DW-1:0]   data,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rdy,
  input  logic [CREDIT_W-1:0]   write_credit,
  input  logic                  w_full,
  output logic                  fifo_wr,
  output logic [DW-1:0]         fifo_wdata,
  output logic                  busy,
  output logic                  err_len
`ifdef EHL_FIFO_WARB_STAT_EN
  ,
  output logic [N_REQ*16-1:0]   stall_cnt
`endif
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (CREDIT_W > LEN_W + 1) ? CREDIT_W : LEN_W + 1;
  localparam logic [31:0] FSZ = 32'(FIFO_SIZE);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]     own_q, own_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [LEN_W-1:0]  len_a [N_REQ];
  logic [DW-1:0]     data_a [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      len_a[i]  = len[i*LEN_W +: LEN_W];
      data_a[i] = data[i*DW +: DW];
    end
  end

  // first requester at or after rr_q, wrapping at N_REQ
  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  int            scan_j;

  always_comb begin
    found  = 1'b0;
    win    = '0;
    idx    = '0;
    scan_j = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_j = int'(rr_q) + k;
      if (scan_j >= N_REQ) scan_j = scan_j - N_REQ;
      idx = PW'(scan_j);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  logic [LEN_W-1:0] win_len, eff_len;
  logic             too_long, credit_ok;
  logic [PW-1:0]    rr_nxt;

  assign win_len   = len_a[win];
  assign eff_len   = (win_len == '0) ? LEN_W'(1) : win_len;
  assign too_long  = 32'(eff_len) > FSZ;
  assign credit_ok = CW'(eff_len) <= CW'(write_credit);
  assign rr_nxt    = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);

  assign busy       = (state_q == BURST);
  assign gnt        = gnt_q;
  assign rdy        = w_full ? '0 : gnt_q;
  assign fifo_wr    = |(vld & rdy);
  assign fifo_wdata = busy ? data_a[own_q] : '0;
  assign err_len    = err_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          if (too_long) begin
            err_d = 1'b1;
            rr_d  = rr_nxt;
          end else if (credit_ok) begin
            state_d    = BURST;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            own_d      = win;
            cnt_d      = eff_len;
            rr_d       = rr_nxt;
          end
        end
      end
      BURST: begin
        if (fifo_wr) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef EHL_FIFO_WARB_STAT_EN
  logic [15:0] stall_q [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    always_ff @(posedge wclk or negedge reset_n) begin
      if (!reset_n) begin
        stall_q[g] <= '0;
      end else if (req[g] && !gnt_q[g] && stall_q[g] != 16'hFFFF) begin
        stall_q[g] <= stall_q[g] + 16'd1;
      end
    end
    assign stall_cnt[g*16 +: 16] = stall_q[g];
  end
`endif

endmodule
